// File: rtl/cam_pkg.sv
// Shared types and default parameters for the camera-to-SDRAM burst writer.
package cam_pkg;

  localparam int BURST_LEN_DEF  = 8;
  localparam int FIFO_DEPTH_DEF = 16;
  localparam int ADDR_W_DEF     = 22;
  localparam int FRAME_BASE_DEF = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } wr_state_t;

  // Width of a burst-length field able to hold the value burst_len itself.
  function automatic int len_bits(input int burst_len);
    return $clog2(burst_len) + 1;
  endfunction

endpackage

// File: rtl/cam_burst_wr_if.sv
// SDRAM write-side handshake between the burst writer (master) and the controller (slave).
interface cam_burst_wr_if import cam_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = len_bits(BURST_LEN_DEF)
);
  logic              sdr_wr_req;
  logic [ADDR_W-1:0] sdr_wr_addr;
  logic [LEN_W-1:0]  sdr_wr_len;
  logic              sdr_wr_ack;
  logic              sdr_wr_pop;
  logic [15:0]       sdr_wr_data;

  modport master (
    output sdr_wr_req, sdr_wr_addr, sdr_wr_len, sdr_wr_data,
    input  sdr_wr_ack, sdr_wr_pop
  );

  modport slave (
    input  sdr_wr_req, sdr_wr_addr, sdr_wr_len, sdr_wr_data,
    output sdr_wr_ack, sdr_wr_pop
  );
endinterface

// File: rtl/sync_fifo_16.sv
// Single-clock show-ahead FIFO of 16-bit words with occupancy count.
module sync_fifo_16 import cam_pkg::*; #(
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic                 pop,
  input  logic [15:0]          din,
  output logic [15:0]          dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                 full,
  output logic                 empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_idx;
  logic [PW-1:0] rd_idx;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Head word is forced to zero while empty so the bus reads 0 out of reset.
  assign dout = empty ? 16'h0000 : mem[rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + PW'(1);
      if (do_pop)  rd_idx <= rd_idx + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/cam_burst_wr.sv
// Buffers captured RGB565 pixels and writes them to SDRAM as length-tagged bursts,
// flushing the partial tail at frame end and pulsing frame_done once drained.
module cam_burst_wr import cam_pkg::*; #(
  parameter int BURST_LEN  = BURST_LEN_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FRAME_BASE = FRAME_BASE_DEF
) (
  input  logic        cmos_pclk,
  input  logic        rst_n,
  input  logic [15:0] data_16b,
  input  logic        data_16b_en,
  input  logic        cmos_data_valid,
  cam_burst_wr_if.master sdr,
  output logic        frame_done,
  output logic        fifo_ovf
);
  localparam int LEN_W = len_bits(BURST_LEN);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LEN_W-1:0]  FULL_LEN  = LEN_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]  BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FRAME_BASE);

  wr_state_t         state, next_state;
  logic [LEN_W-1:0]  len_r, next_len;
  logic [LEN_W-1:0]  pop_cnt;
  logic [ADDR_W-1:0] wr_ptr;
  logic              valid_d, frame_start, frame_end;
  logic              flush_pend, reload_pend;

  logic [CNT_W-1:0]  fifo_count;
  logic [15:0]       fifo_dout;
  logic              fifo_full, fifo_empty;
  logic              push_req, ovf_event, pop_fire, xfer_last;

  assign push_req  = data_16b_en & cmos_data_valid;
  assign ovf_event = push_req & fifo_full;
  assign pop_fire  = (state == XFER) & sdr.sdr_wr_pop & ~fifo_empty;
  assign xfer_last = pop_fire & (pop_cnt == len_r - LEN_W'(1));

  sync_fifo_16 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (cmos_pclk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop_fire),
    .din   (data_16b),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sdr.sdr_wr_data = fifo_dout;

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    next_len   = len_r;
    case (state)
      IDLE: begin
        if (fifo_count >= BURST_CNT) begin
          next_state = REQ;
          next_len   = FULL_LEN;
        end else if (flush_pend && !fifo_empty) begin
          // count is below BURST_LEN in this branch, so it fits the length field
          next_state = REQ;
          next_len   = fifo_count[LEN_W-1:0];
        end else if (flush_pend) begin
          next_state = DONE;
        end
      end
      REQ:     if (sdr.sdr_wr_ack) next_state = XFER;
      XFER:    if (xfer_last) next_state = IDLE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sdr.sdr_wr_req  = 1'b0;
    sdr.sdr_wr_addr = '0;
    sdr.sdr_wr_len  = '0;
    frame_done      = 1'b0;
    case (state)
      REQ: begin
        sdr.sdr_wr_req  = 1'b1;
        sdr.sdr_wr_addr = wr_ptr;
        sdr.sdr_wr_len  = len_r;
      end
      XFER: begin
        sdr.sdr_wr_addr = wr_ptr;
        sdr.sdr_wr_len  = len_r;
      end
      DONE:    frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge cmos_pclk or negedge rst_n) begin
    if (!rst_n) begin
      valid_d     <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      fifo_ovf    <= 1'b0;
      flush_pend  <= 1'b0;
      reload_pend <= 1'b0;
      len_r       <= '0;
      pop_cnt     <= '0;
      wr_ptr      <= BASE_ADDR;
    end else begin
      valid_d     <= cmos_data_valid;
      frame_start <= cmos_data_valid & ~valid_d;
      frame_end   <= ~cmos_data_valid & valid_d;
      len_r       <= next_len;

      if (ovf_event)        fifo_ovf <= 1'b1;
      else if (frame_start) fifo_ovf <= 1'b0;

      if (frame_end)          flush_pend <= 1'b1;
      else if (state == DONE) flush_pend <= 1'b0;

      if (state != XFER) pop_cnt <= '0;
      else if (pop_fire) pop_cnt <= pop_cnt + LEN_W'(1);

      // A new frame arriving while the old one still drains must not move the
      // pointer until the old frame's tail has been written.
      if (state == DONE)                  reload_pend <= 1'b0;
      else if (frame_start && flush_pend) reload_pend <= 1'b1;

      if (state == DONE && (reload_pend || frame_start)) wr_ptr <= BASE_ADDR;
      else if (frame_start && !flush_pend)              wr_ptr <= BASE_ADDR;
      else if (xfer_last)                               wr_ptr <= wr_ptr + ADDR_W'(len_r);
    end
  end

endmodule
